// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register indices, Status/Cause field positions,
// exception codes, sequencer states and the interrupt-priority helper.
package cp0_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam int ST_IE      = 0;
  localparam int ST_EXL     = 4;
  localparam int ST_IM_LSB  = 8;
  localparam int CA_EXC_LSB = 2;
  localparam int CA_IP_LSB  = 8;
  localparam int CA_BD      = 31;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_TRAP = 5'd13;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLUSH    = 2'd1,
    S_REDIRECT = 2'd2
  } cp0_state_e;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] k;
    k = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) begin
        k = 3'(i);
      end else begin
        k = k;
      end
    end
    return k;
  endfunction

endpackage

// File: rtl/irq_sync_latch.sv
// Two-flop synchroniser for the external interrupt lines, followed by the
// per-line pending latch (edge lines latch rising edges, level lines pass through).
module irq_sync_latch #(
  parameter int         N         = 6,
  parameter logic [7:0] EDGE_MASK = 8'h00
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_irq,
  input  logic [N-1:0] i_clr,
  output logic [N-1:0] o_ip
);

  logic [N-1:0] r_s1;
  logic [N-1:0] r_s2;
  logic [N-1:0] r_s3;
  logic [N-1:0] r_ip_edge;
  logic [N-1:0] w_edge_lines;
  logic [N-1:0] w_rise;

  assign w_edge_lines = EDGE_MASK[N-1:0];
  assign w_rise       = r_s2 & ~r_s3 & w_edge_lines;

  // Synchroniser chain plus latched edge bits; a new edge beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1      <= {N{1'b0}};
      r_s2      <= {N{1'b0}};
      r_s3      <= {N{1'b0}};
      r_ip_edge <= {N{1'b0}};
    end else begin
      r_s1      <= i_irq;
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_ip_edge <= ((r_ip_edge & ~i_clr) | w_rise) & w_edge_lines;
    end
  end

  assign o_ip = (r_s2 & ~w_edge_lines) | r_ip_edge;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: Status/Cause/EPC, interrupt
// pending logic and the flush-then-redirect sequencer.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_IRQ      = 6,
  parameter logic [7:0]  IRQ_EDGE     = 8'h00,
  parameter bit          VECTORED     = 1'b0,
  parameter logic [31:0] EXC_BASE     = 32'h0000_0004,
  parameter int          VEC_SPACING  = 32,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid,
  input  logic [31:0]        instr_pc,
  input  logic               in_delay_slot,
  input  logic               exc_req,
  input  logic [4:0]         exc_code,
  input  logic               eret,
  input  logic               mtc0,
  input  logic [4:0]         cp0_addr,
  input  logic [31:0]        wdata,
  input  logic [NUM_IRQ-1:0] irq,
  output logic [31:0]        rdata,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        redirect_pc,
  output logic               exc_busy,
  output logic [31:0]        status_o,
  output logic [31:0]        epc_o
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_001F | (((32'h1 << NUM_IRQ) - 32'h1) << 8);
  localparam logic [1:0]  FLUSH_LAST   = 2'(FLUSH_CYCLES - 1);

  logic [31:0]        r_status;
  logic [31:0]        r_epc;
  logic [4:0]         r_exc_code;
  logic               r_bd;
  cp0_state_e         r_state;
  logic [1:0]         r_cnt;
  logic [31:0]        r_target;
  logic [31:0]        r_redirect_pc;
  logic               r_flush;
  logic               r_pc_redirect;
  logic               r_busy;

  cp0_state_e         w_next_state;
  logic [1:0]         w_cnt_next;
  logic [NUM_IRQ-1:0] w_ip;
  logic [NUM_IRQ-1:0] w_pend;
  logic [NUM_IRQ-1:0] w_clr;
  logic [7:0]         w_pend8;
  logic [2:0]         w_k;
  logic [31:0]        w_vec_target;
  logic [31:0]        w_target;
  logic [31:0]        w_cause;
  logic               w_idle_v;
  logic               w_take_exc;
  logic               w_take_eret;
  logic               w_take_int;
  logic               w_accept;
  logic               w_wr;

  irq_sync_latch #(
    .N         (NUM_IRQ),
    .EDGE_MASK (IRQ_EDGE)
  ) u_irq (
    .clk   (clk),
    .rst_n (rst_n),
    .i_irq (irq),
    .i_clr (w_clr),
    .o_ip  (w_ip)
  );

  // Event acceptance: exc_req beats eret beats interrupts, only in IDLE.
  always_comb begin
    w_pend      = w_ip & r_status[ST_IM_LSB +: NUM_IRQ];
    w_idle_v    = (r_state == S_IDLE) && instr_valid;
    w_take_exc  = w_idle_v && exc_req && !r_status[ST_EXL];
    w_take_eret = w_idle_v && !exc_req && eret;
    w_take_int  = w_idle_v && !exc_req && !eret && r_status[ST_IE] &&
                  !r_status[ST_EXL] && (|w_pend);
    w_accept    = w_take_exc || w_take_eret || w_take_int;
    w_wr        = w_idle_v && mtc0 && !w_accept;
  end

  // Vector slot of the highest-priority pending line and the redirect target.
  always_comb begin
    w_pend8                = 8'h00;
    w_pend8[NUM_IRQ-1:0]   = w_pend;
    w_k                    = lowest_set(w_pend8);
    w_vec_target           = EXC_BASE + 32'(VEC_SPACING) * ({29'd0, w_k} + 32'd1);
    if (w_take_eret) begin
      w_target = r_epc;
    end else if (w_take_int && VECTORED) begin
      w_target = w_vec_target;
    end else begin
      w_target = EXC_BASE;
    end
  end

  // Writing 0 to a Cause IP bit clears a latched edge line.
  always_comb begin
    if (w_wr && (cp0_addr == CP0_CAUSE)) begin
      w_clr = ~wdata[CA_IP_LSB +: NUM_IRQ];
    end else begin
      w_clr = {NUM_IRQ{1'b0}};
    end
  end

  // Architectural Status/Cause/EPC state; events take precedence over mtc0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_status   <= 32'h0;
      r_epc      <= 32'h0;
      r_exc_code <= 5'd0;
      r_bd       <= 1'b0;
    end else if (w_take_exc || w_take_int) begin
      r_epc            <= in_delay_slot ? (instr_pc - 32'd4) : instr_pc;
      r_bd             <= in_delay_slot;
      r_exc_code       <= w_take_exc ? exc_code : EXC_INT;
      r_status[ST_EXL] <= 1'b1;
    end else if (w_take_eret) begin
      r_status[ST_EXL] <= 1'b0;
    end else if (w_wr) begin
      case (cp0_addr)
        CP0_STATUS: r_status <= wdata & STATUS_WMASK;
        CP0_EPC:    r_epc    <= wdata;
        default:    r_epc    <= r_epc;
      endcase
    end else begin
      r_epc <= r_epc;
    end
  end

  // Sequencer next state and flush-length counter.
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next_state = S_FLUSH;
          w_cnt_next   = 2'd0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (r_cnt == FLUSH_LAST) begin
          w_next_state = S_REDIRECT;
        end else begin
          w_cnt_next = r_cnt + 2'd1;
        end
      end
      S_REDIRECT: w_next_state = S_IDLE;
      default:    w_next_state = S_IDLE;
    endcase
  end

  // State, captured target and registered pipeline-control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 2'd0;
      r_target      <= 32'h0;
      r_redirect_pc <= 32'h0;
      r_flush       <= 1'b0;
      r_pc_redirect <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_cnt_next;
      r_target      <= w_accept ? w_target : r_target;
      r_redirect_pc <= (w_next_state == S_REDIRECT) ? r_target : r_redirect_pc;
      r_flush       <= (w_next_state != S_IDLE);
      r_pc_redirect <= (w_next_state == S_REDIRECT);
      r_busy        <= (w_next_state != S_IDLE);
    end
  end

  // Cause view and the combinational CP0 read port.
  always_comb begin
    w_cause                            = 32'h0;
    w_cause[CA_EXC_LSB +: 5]           = r_exc_code;
    w_cause[CA_IP_LSB +: NUM_IRQ]      = w_ip;
    w_cause[CA_BD]                     = r_bd;
    case (cp0_addr)
      CP0_STATUS: rdata = r_status;
      CP0_CAUSE:  rdata = w_cause;
      CP0_EPC:    rdata = r_epc;
      default:    rdata = 32'h0;
    endcase
  end

  assign flush       = r_flush;
  assign pc_redirect = r_pc_redirect;
  assign redirect_pc = r_redirect_pc;
  assign exc_busy    = r_busy;
  assign status_o    = r_status;
  assign epc_o       = r_epc;

endmodule
